// File: rtl/team_05_wb_pkg.sv
// Shared register-map constants for the team 05 Wishbone slave.
package team_05_wb_pkg;

    // Register offsets as seen on adr_i[3:2]
    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] TXDATA_OFS = 2'd2;
    localparam logic [1:0] RESULT_OFS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLR_BIT    = 2;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_CNT_LSB   = 2;
    localparam int ST_OVF_BIT   = 8;
    localparam int ST_OVR_BIT   = 9;
    localparam int ST_PEND_BIT  = 10;
    localparam int ST_BUSY_BIT  = 11;

endpackage

// File: rtl/team_05_cmd_fifo.sv
// Circular command buffer, 32-bit entries, power-of-two depth.
// Clear has priority over push and pop in the same cycle.
module team_05_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [31:0]      data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [31:0]      head_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i & ~empty_o & ~clear_i;
        // A full buffer still accepts a push when the head leaves in the same cycle
        do_push  = push_i & (~full_o | do_pop) & ~clear_i;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/team_05_wb_slave.sv
// Wishbone classic slave: CTRL/STATUS/TXDATA/RESULT window, command FIFO
// toward the core and result capture with a level interrupt.
module team_05_wb_slave
    import team_05_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] cmd_data_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    input  logic        core_busy_i,
    output logic        irq_o
);
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             ovf_q, ovf_d;
    logic             ovr_q, ovr_d;
    logic             pend_q, pend_d;
    logic [31:0]      result_q, result_d;
    logic             irq_q, irq_d;

    logic             in_win, req, wr, rd;
    logic [1:0]       ofs;
    logic             fifo_push, fifo_pop, fifo_clear;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_head;
    logic [31:0]      status;
    logic [31:0]      rd_mux;
    logic             unused_adr;

    assign unused_adr = ^adr_i[1:0];

    assign in_win = (adr_i[31:4] == BASE_ADDR[31:4]);
    // ack_q masks the request so every access takes exactly two cycles
    assign req    = cyc_i & stb_i & in_win & ~ack_q;
    assign wr     = req & we_i;
    assign rd     = req & ~we_i;
    assign ofs    = adr_i[3:2];

    assign cmd_valid_o = en_q & ~fifo_empty;
    assign cmd_data_o  = fifo_head;
    assign fifo_pop    = cmd_valid_o & cmd_ready_i;
    assign fifo_push   = wr & (ofs == TXDATA_OFS) & (sel_i == 4'hF);
    assign fifo_clear  = wr & (ofs == CTRL_OFS) & sel_i[0] & dat_i[CTRL_CLR_BIT];

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = irq_q;

    team_05_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .data_i  (dat_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    always_comb begin
        status                         = '0;
        status[ST_EMPTY_BIT]           = fifo_empty;
        status[ST_FULL_BIT]            = fifo_full;
        status[ST_CNT_LSB +: CNT_W]    = fifo_count;
        status[ST_OVF_BIT]             = ovf_q;
        status[ST_OVR_BIT]             = ovr_q;
        status[ST_PEND_BIT]            = pend_q;
        status[ST_BUSY_BIT]            = core_busy_i;
    end

    always_comb begin
        rd_mux = '0;
        case (ofs)
            CTRL_OFS: begin
                rd_mux[CTRL_EN_BIT]     = en_q;
                rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            STATUS_OFS: rd_mux = status;
            RESULT_OFS: rd_mux = result_q;
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        ack_d    = req;
        dat_d    = rd ? rd_mux : '0;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        ovr_d    = ovr_q;
        pend_d   = pend_q;
        result_d = result_q;
        irq_d    = irq_en_q & pend_q;

        if (wr && ofs == CTRL_OFS && sel_i[0]) begin
            en_d     = dat_i[CTRL_EN_BIT];
            irq_en_d = dat_i[CTRL_IRQ_EN_BIT];
        end
        if (wr && ofs == STATUS_OFS && sel_i[1]) begin
            if (dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
            if (dat_i[ST_OVR_BIT]) ovr_d = 1'b0;
        end
        if (rd && ofs == RESULT_OFS) begin
            pend_d = 1'b0;
        end

        // New events win over a same-cycle clear so nothing is silently lost
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
        if (res_valid_i) begin
            result_d = res_data_i;
            pend_d   = 1'b1;
            if (pend_q) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            pend_q   <= 1'b0;
            result_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
            pend_q   <= pend_d;
            result_q <= result_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_team_05_wb_slave.sv
// Scoreboard bench for team_05_wb_slave: expected read data and expected
// command words are queued at stimulus time and popped when the DUT delivers.
module tb_team_05_wb_slave;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_TXDATA = BASE + 32'h8;
    localparam logic [31:0] A_RESULT = BASE + 32'hC;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        cyc_i, stb_i, we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i, dat_i, dat_o;
    logic        ack_o;
    logic        cmd_valid_o, cmd_ready_i;
    logic [31:0] cmd_data_o;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        core_busy_i;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cmd_q [$];
    logic [31:0] rd_q  [$];

    always #5 clk_i = ~clk_i;

    team_05_wb_slave #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .ack_o       (ack_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_data_o  (cmd_data_o),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .core_busy_i (core_busy_i),
        .irq_o       (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Core side: every accepted command must match the oldest expected word
    always @(negedge clk_i) begin
        if (nrst_i && cmd_valid_o && cmd_ready_i) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 32'd0, 32'd1);
            else chk("cmd_data", cmd_data_o, cmd_q.pop_front());
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic acked, output logic [31:0] rdat);
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = wdat;
        acked = 1'b0;
        rdat  = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin
                acked = 1'b1;
                rdat  = dat_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        logic        a;
        logic [31:0] r;
        wb_xfer(adr, 1'b1, sel, wdat, a, r);
        chk("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wb_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic        a;
        logic [31:0] r;
        rd_q.push_back(exp);
        wb_xfer(adr, 1'b0, 4'hF, 32'd0, a, r);
        chk("rd_ack", {31'd0, a}, 32'd1);
        if (a) chk(tag, r, rd_q.pop_front());
        else void'(rd_q.pop_front());
    endtask

    task automatic push_cmd(input logic [31:0] d, input bit expect_delivery);
        if (expect_delivery) cmd_q.push_back(d);
        wb_wr(A_TXDATA, d, 4'hF);
    endtask

    task automatic res_pulse(input logic [31:0] d);
        @(posedge clk_i); #1;
        res_valid_i = 1'b1; res_data_i = d;
        @(posedge clk_i); #1;
        res_valid_i = 1'b0;
    endtask

    initial begin
        logic        a;
        logic [31:0] r;
        nrst_i = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
        adr_i = '0; dat_i = '0;
        cmd_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; core_busy_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i) nrst_i = 1'b1;
        wb_rd("rst_status", A_STATUS, 32'h0000_0001);

        // Single command straight through to the core
        wb_wr(A_CTRL, 32'h3, 4'h1);
        cmd_ready_i = 1'b1;
        push_cmd(32'hA5A5_0001, 1'b1);
        repeat (3) @(posedge clk_i);
        wb_rd("status_after_one", A_STATUS, 32'h0000_0001);

        // Fill past depth while disabled: fifth word is dropped
        cmd_ready_i = 1'b0;
        wb_wr(A_CTRL, 32'h2, 4'h1);
        for (int i = 1; i <= 5; i++) push_cmd(32'(i), i <= 4);
        #1 chk("disabled_valid", {31'd0, cmd_valid_o}, 32'd0);
        wb_rd("status_full_ovf", A_STATUS, 32'h0000_0112);
        cmd_ready_i = 1'b1;
        wb_wr(A_CTRL, 32'h3, 4'h1);
        repeat (8) @(posedge clk_i);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        wb_rd("status_drained", A_STATUS, 32'h0000_0101);

        // Overflow W1C, then fifo_clear with two queued entries
        wb_wr(A_STATUS, 32'h0000_0100, 4'h2);
        wb_rd("status_ovf_clr", A_STATUS, 32'h0000_0001);
        cmd_ready_i = 1'b0;
        push_cmd(32'h0000_00AA, 1'b0);
        push_cmd(32'h0000_00BB, 1'b0);
        wb_rd("status_two", A_STATUS, 32'h0000_0008);
        wb_wr(A_CTRL, 32'h7, 4'h1);
        wb_rd("status_cleared", A_STATUS, 32'h0000_0001);
        wb_rd("ctrl_readback", A_CTRL, 32'h0000_0003);

        // Result capture and interrupt
        res_pulse(32'hDEAD_BEEF);
        chk("irq_lag", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("irq_set", {31'd0, irq_o}, 32'd1);
        wb_rd("status_pend", A_STATUS, 32'h0000_0401);
        wb_rd("result", A_RESULT, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
        res_pulse(32'h0000_1111);
        res_pulse(32'h0000_2222);
        wb_rd("status_overrun", A_STATUS, 32'h0000_0601);
        wb_rd("result_overwrite", A_RESULT, 32'h0000_2222);
        wb_wr(A_STATUS, 32'h0000_0200, 4'h2);
        core_busy_i = 1'b1;
        wb_rd("status_busy", A_STATUS, 32'h0000_0801);
        core_busy_i = 1'b0;

        // Out-of-window access and partial TXDATA write
        wb_xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0000_0007, a, r);
        chk("oow_noack", {31'd0, a}, 32'd0);
        wb_rd("ctrl_after_oow", A_CTRL, 32'h0000_0003);
        wb_rd("status_after_oow", A_STATUS, 32'h0000_0001);
        wb_wr(A_TXDATA, 32'h1234_5678, 4'h3);
        wb_rd("status_partial", A_STATUS, 32'h0000_0001);
        wb_rd("txdata_read", A_TXDATA, 32'h0000_0000);

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
